disc_flipper: RTL and testbench
===============================

Name: disc_flipper

Overview:
- Downstream of the per-direction move validator.
- After the move controller collects the eight direction verdicts for a candidate square, this block commits the move to board memory:
  - writes the mover's disc at the placed square;
  - walks each validated direction, flipping opponent discs until it reaches a disc of the mover's colour.
- Owns the board memory port, via ctrl_mem, while busy.
- Returns a done pulse and a flip count to the move controller.

Parameters:
- ADDR_W, 7, board memory address width.
- BOARD_DIM, 8, board side length. Cell address = row*BOARD_DIM + col, valid range 0..63.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- s_addr_in  in  7  placed square (0..63)
- player  in  1  0 = black (disc code 2'b01), 1 = white (disc code 2'b10)
- dir_mask  in  8  bit i set = direction i validated
- data_in  in  2  memory read data; 00 empty, 01 black, 10 white, 11 invalid
- addr_out  out  7  memory address
- data_out  out  2  memory write data
- wren_o  out  1  memory write enable
- ctrl_mem  out  1  1 = this block drives the memory port
- busy  out  1  high from the cycle after start until done
- done_o  out  1  one-cycle completion pulse
- flip_count  out  5  number of discs flipped; held until the next start

Behaviour:
- Reset: reset=0 at a clock edge forces state IDLE and clears every output (addr_out, data_out, wren_o, ctrl_mem, busy, done_o, flip_count = 0) on that edge.
  - Reset mid-operation aborts without any further write; partial flips remain in memory.
- Direction index → step:
  - 0:+1, 1:-1, 2:+8, 3:-8, 4:+7, 5:-7, 6:+9, 7:-9.
  - Directions are processed in ascending index order.
- Memory: synchronous read. data_in reflects the addr_out presented, with wren_o=0, in the previous cycle.
- On start in IDLE:
  - latch s_addr_in, player, dir_mask;
  - own = player ? 2'b10 : 2'b01; opp = ~own (2 bits);
  - clear flip_count; assert busy.
  - start while busy is ignored.
- State PLACE:
  - if latched mask == 0: no write; go to DONE.
  - otherwise: ctrl_mem=1, addr_out=s_addr, data_out=own, wren_o=1 for one cycle; go to DIR_SEL.
- State DIR_SEL:
  - pick the lowest set bit of the remaining mask and clear it;
  - cur = s_addr; go to STEP.
  - No bits remaining → DONE.
- State STEP:
  - compute nxt = cur + step using signed arithmetic at width ADDR_W+1.
  - Boundary abort: nxt < 0, nxt > 63, or a column wrap. Column wrap means:
    - steps ±1, +9, -7 require col(cur) != 7 for +1/+9/-7;
    - steps -1, -9, +7 require col(cur) != 0.
  - On abort: no access; return to DIR_SEL.
  - Otherwise: addr_out=nxt, wren_o=0; cur <= nxt; go to WAIT.
- State WAIT: one cycle for read latency; go to CHK.
- State CHK, acting on data_in:
  - == opp: go to WR.
  - == own, 00 or 11: direction finished; go to DIR_SEL.
- State WR:
  - addr_out=cur, data_out=own, wren_o=1;
  - flip_count += 1, saturating at 31;
  - go to STEP.
- State DONE:
  - done_o=1 for exactly one cycle; ctrl_mem=0, busy=0, wren_o=0; go to IDLE.
- ctrl_mem is 1 in every state from PLACE through WR inclusive, and 0 in IDLE and DONE.
- wren_o is high only in PLACE and WR.
- Per-flip cost: STEP+WAIT+CHK+WR = 4 cycles. An empty-mask request completes with done_o two cycles after start.

Test Plan:
- Opening board; black (player=0) places at 19 with dir_mask=8'b0000_0100 (+8 direction); opp disc at 27, own at 35 → writes (19,01) then (27,01); flip_count=1; done_o pulse; no write to 35.
- White places at 20; mask bits 0 and 2 set; opp discs at 21,22 (own at 23) and at 28 (own at 36) → write order 20, 21, 22, 28; flip_count=3; direction 0 fully completes before direction 2 starts.
- s_addr_in=7 (col 7), mask bit 0 forced set → +1 aborts on column wrap; only the placed-disc write occurs; flip_count=0.
- dir_mask=0, start pulse → no wren_o at any cycle; done_o exactly 2 cycles after start; busy low afterwards.
- Assert reset=0 in the cycle after the first flip WR → next edge: IDLE, all outputs 0, no further wren_o; a subsequent start runs normally.
- start re-pulsed while busy → ignored; single done_o; latched s_addr/mask unchanged.

Source files
------------

// File: rtl/disc_flipper.sv
// -----------------------------------------------------------------------------
// disc_flipper
//   Commits a validated move to board memory. It first writes the mover's disc
//   at the placed square. It then walks every validated direction in ascending
//   index order and turns opponent discs into the mover's colour until the walk
//   reaches a cell that is not an opponent disc. It owns the board memory port
//   while busy.
//
// Ports
//   clock, reset       system clock; synchronous active-low reset
//   start              one-cycle request, only accepted in IDLE
//   s_addr_in          placed square (row*BOARD_DIM + col)
//   player             0 = black (01), 1 = white (10)
//   dir_mask           bit i set = direction i validated
//   data_in            synchronous read data (one cycle after address)
//   addr_out, data_out memory address / write data
//   wren_o             memory write enable
//   ctrl_mem           1 while this block owns the memory port
//   busy               high from the cycle after start until done
//   done_o             one-cycle completion pulse
//   flip_count         discs flipped (saturates at 31), held until next start
//
// Timing note: address/data/write-enable are registered from the decision made
// in the current state, so each access appears on the port one cycle after the
// state that issued it. A read issued in STEP is presented during WAIT and its
// data is back in CHK. Status outputs (busy, ctrl_mem, done_o) are registered
// from the next state, so they line up with the state itself.
// -----------------------------------------------------------------------------
module disc_flipper #(
    parameter int ADDR_W    = 7,
    parameter int BOARD_DIM = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] s_addr_in,
    input  logic              player,
    input  logic [7:0]        dir_mask,
    input  logic [1:0]        data_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic [1:0]        data_out,
    output logic              wren_o,
    output logic              ctrl_mem,
    output logic              busy,
    output logic              done_o,
    output logic [4:0]        flip_count
);

    localparam int SW = ADDR_W + 1;

    localparam logic signed [SW-1:0] ZERO_S   = SW'(0);
    localparam logic signed [SW-1:0] ONE_S    = SW'(1);
    localparam logic signed [SW-1:0] ROW_S    = SW'(BOARD_DIM);
    localparam logic signed [SW-1:0] DIAG_L_S = SW'(BOARD_DIM - 1);
    localparam logic signed [SW-1:0] DIAG_R_S = SW'(BOARD_DIM + 1);
    localparam logic signed [SW-1:0] MAX_CELL = SW'(BOARD_DIM * BOARD_DIM - 1);
    localparam logic [ADDR_W-1:0]    LAST_COL = ADDR_W'(BOARD_DIM - 1);
    localparam logic [ADDR_W-1:0]    FIRST_COL = ADDR_W'(0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PLACE   = 3'd1,
        S_DIR_SEL = 3'd2,
        S_STEP    = 3'd3,
        S_WAIT    = 3'd4,
        S_CHK     = 3'd5,
        S_WR      = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    // Signed cell offset for each direction index.
    function automatic logic signed [SW-1:0] dir_step(input logic [2:0] d);
        case (d)
            3'd0:    return ONE_S;
            3'd1:    return -ONE_S;
            3'd2:    return ROW_S;
            3'd3:    return -ROW_S;
            3'd4:    return DIAG_L_S;
            3'd5:    return -DIAG_L_S;
            3'd6:    return DIAG_R_S;
            3'd7:    return -DIAG_R_S;
            default: return ZERO_S;
        endcase
    endfunction

    // Directions whose step moves one column to the right (+1, -7, +9).
    function automatic logic moves_right(input logic [2:0] d);
        return (d == 3'd0) || (d == 3'd5) || (d == 3'd6);
    endfunction

    // Directions whose step moves one column to the left (-1, +7, -9).
    function automatic logic moves_left(input logic [2:0] d);
        return (d == 3'd1) || (d == 3'd4) || (d == 3'd7);
    endfunction

    // Index of the lowest set bit; only meaningful for a non-zero mask.
    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  s_addr_q, s_addr_d;
    logic [1:0]         own_q, own_d;
    logic [7:0]         rem_q, rem_d;
    logic [2:0]         dir_q, dir_d;
    logic [ADDR_W-1:0]  cur_q, cur_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [1:0]         data_q, data_d;
    logic               wren_q, wren_d;
    logic               ctrl_q, ctrl_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [4:0]         count_q, count_d;

    logic signed [SW-1:0] nxt_s;
    logic [ADDR_W-1:0]    col_s;
    logic                 abort_s;

    // Neighbour cell of cur along the active direction, and whether it is off-board.
    always_comb begin
        nxt_s   = $signed({1'b0, cur_q}) + dir_step(dir_q);
        col_s   = cur_q % ADDR_W'(BOARD_DIM);
        abort_s = (nxt_s < ZERO_S) || (nxt_s > MAX_CELL)
                  || (moves_right(dir_q) && (col_s == LAST_COL))
                  || (moves_left(dir_q)  && (col_s == FIRST_COL));
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d  = state_q;
        s_addr_d = s_addr_q;
        own_d    = own_q;
        rem_d    = rem_q;
        dir_d    = dir_q;
        cur_d    = cur_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wren_d   = 1'b0;
        count_d  = count_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    s_addr_d = s_addr_in;
                    own_d    = player ? 2'b10 : 2'b01;
                    rem_d    = dir_mask;
                    count_d  = 5'd0;
                    state_d  = S_PLACE;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_PLACE: begin
                if (rem_q == 8'd0) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = s_addr_q;
                    data_d  = own_q;
                    wren_d  = 1'b1;
                    state_d = S_DIR_SEL;
                end
            end
            S_DIR_SEL: begin
                if (rem_q == 8'd0) begin
                    state_d = S_DONE;
                end else begin
                    dir_d   = lowest_bit(rem_q);
                    // Clear the lowest set bit.
                    rem_d   = rem_q & (rem_q - 8'd1);
                    cur_d   = s_addr_q;
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (abort_s) begin
                    state_d = S_DIR_SEL;
                end else begin
                    addr_d  = nxt_s[ADDR_W-1:0];
                    cur_d   = nxt_s[ADDR_W-1:0];
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                state_d = S_CHK;
            end
            S_CHK: begin
                if (data_in == ~own_q) begin
                    state_d = S_WR;
                end else begin
                    state_d = S_DIR_SEL;
                end
            end
            S_WR: begin
                addr_d  = cur_q;
                data_d  = own_q;
                wren_d  = 1'b1;
                count_d = (count_q == 5'd31) ? count_q : count_q + 5'd1;
                state_d = S_STEP;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ctrl_d = (state_d != S_IDLE) && (state_d != S_DONE);
        busy_d = ctrl_d;
        done_d = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            s_addr_q <= '0;
            own_q    <= 2'b01;
            rem_q    <= 8'd0;
            dir_q    <= 3'd0;
            cur_q    <= '0;
            addr_q   <= '0;
            data_q   <= 2'b00;
            wren_q   <= 1'b0;
            ctrl_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= 5'd0;
        end else begin
            state_q  <= state_d;
            s_addr_q <= s_addr_d;
            own_q    <= own_d;
            rem_q    <= rem_d;
            dir_q    <= dir_d;
            cur_q    <= cur_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wren_q   <= wren_d;
            ctrl_q   <= ctrl_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            count_q  <= count_d;
        end
    end

    assign addr_out   = addr_q;
    assign data_out   = data_q;
    assign wren_o     = wren_q;
    assign ctrl_mem   = ctrl_q;
    assign busy       = busy_q;
    assign done_o     = done_q;
    assign flip_count = count_q;

endmodule

// File: tb/tb_disc_flipper.sv
module tb_disc_flipper;

    logic       clock;
    logic       reset;
    logic       start;
    logic [6:0] s_addr_in;
    logic       player;
    logic [7:0] dir_mask;
    logic [1:0] data_in;
    logic [6:0] addr_out;
    logic [1:0] data_out;
    logic       wren_o;
    logic       ctrl_mem;
    logic       busy;
    logic       done_o;
    logic [4:0] flip_count;

    int vectors;
    int miscompares;

    // Board memory model, preload port and observation logs.
    logic [1:0] mem [0:63];
    logic       ld_we;
    logic       ld_clr;
    logic [5:0] ld_addr;
    logic [1:0] ld_data;
    logic [8:0] wlog[$];
    int         done_cnt;

    disc_flipper #(.ADDR_W(7), .BOARD_DIM(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .s_addr_in  (s_addr_in),
        .player     (player),
        .dir_mask   (dir_mask),
        .data_in    (data_in),
        .addr_out   (addr_out),
        .data_out   (data_out),
        .wren_o     (wren_o),
        .ctrl_mem   (ctrl_mem),
        .busy       (busy),
        .done_o     (done_o),
        .flip_count (flip_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ld_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 2'b00;
        end else if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end else if (wren_o && (addr_out < 7'd64)) begin
            mem[addr_out[5:0]] <= data_out;
        end
        data_in <= mem[addr_out[5:0]];
        if (wren_o) wlog.push_back({addr_out, data_out});
        if (done_o) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [8:0] exp);
        logic [8:0] got;
        got = (idx < wlog.size()) ? wlog[idx] : 9'h1FF;
        check(tag, {23'd0, got}, {23'd0, exp});
    endtask

    task automatic clear_mem();
        ld_clr = 1'b1;
        tick();
        ld_clr = 1'b0;
    endtask

    task automatic poke(input logic [5:0] a, input logic [1:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_we = 1'b0;
    endtask

    task automatic run_move(input logic p, input logic [6:0] a, input logic [7:0] m);
        player = p; s_addr_in = a; dir_mask = m; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (done_o) break;
            tick();
        end
        check(tag, {31'd0, done_o}, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_addr"}, {25'd0, addr_out}, 32'd0);
        check({tag, "_data"}, {30'd0, data_out}, 32'd0);
        check({tag, "_wren"}, {31'd0, wren_o}, 32'd0);
        check({tag, "_ctrl"}, {31'd0, ctrl_mem}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done_o}, 32'd0);
        check({tag, "_cnt"}, {27'd0, flip_count}, 32'd0);
    endtask

    initial begin
        int base;
        int d0;
        vectors = 0; miscompares = 0; done_cnt = 0;
        reset = 1'b0; start = 1'b0; s_addr_in = 7'd0; player = 1'b0;
        dir_mask = 8'd0; ld_we = 1'b0; ld_clr = 1'b0; ld_addr = 6'd0; ld_data = 2'b00;
        data_in = 2'b00;
        tick(); tick(); tick();
        check_idle_outputs("rst");
        reset = 1'b1;
        tick();

        // Black at 19, +8: flip 27, stop at own disc on 35.
        clear_mem();
        poke(6'd27, 2'b10); poke(6'd35, 2'b01); poke(6'd28, 2'b01);
        base = wlog.size(); d0 = done_cnt;
        run_move(1'b0, 7'd19, 8'b0000_0100);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_ctrl", {31'd0, ctrl_mem}, 32'd1);
        wait_done("t1_done");
        check("t1_cnt", {27'd0, flip_count}, 32'd1);
        tick();
        check("t1_busy_after", {31'd0, busy}, 32'd0);
        check("t1_nwr", wlog.size() - base, 32'd2);
        check_wr("t1_wr0", base, {7'd19, 2'b01});
        check_wr("t1_wr1", base + 1, {7'd27, 2'b01});
        check("t1_m27", {30'd0, mem[27]}, 32'd1);
        check("t1_m35", {30'd0, mem[35]}, 32'd1);
        check("t1_ndone", done_cnt - d0, 32'd1);

        // White at 20, directions 0 and 2.
        clear_mem();
        poke(6'd21, 2'b01); poke(6'd22, 2'b01); poke(6'd23, 2'b10);
        poke(6'd28, 2'b01); poke(6'd36, 2'b10);
        base = wlog.size();
        run_move(1'b1, 7'd20, 8'b0000_0101);
        wait_done("t2_done");
        check("t2_cnt", {27'd0, flip_count}, 32'd3);
        tick();
        check("t2_nwr", wlog.size() - base, 32'd4);
        check_wr("t2_wr0", base, {7'd20, 2'b10});
        check_wr("t2_wr1", base + 1, {7'd21, 2'b10});
        check_wr("t2_wr2", base + 2, {7'd22, 2'b10});
        check_wr("t2_wr3", base + 3, {7'd28, 2'b10});
        check("t2_m22", {30'd0, mem[22]}, 32'd2);
        check("t2_m28", {30'd0, mem[28]}, 32'd2);

        // Column 7, +1 must abort on wrap: cell 8 is untouched.
        clear_mem();
        poke(6'd8, 2'b10); poke(6'd9, 2'b01);
        base = wlog.size();
        run_move(1'b0, 7'd7, 8'b0000_0001);
        wait_done("t3_done");
        check("t3_cnt", {27'd0, flip_count}, 32'd0);
        tick();
        check("t3_nwr", wlog.size() - base, 32'd1);
        check_wr("t3_wr0", base, {7'd7, 2'b01});
        check("t3_m8", {30'd0, mem[8]}, 32'd2);

        // Empty mask: done exactly two cycles after start, no writes.
        base = wlog.size(); d0 = done_cnt;
        run_move(1'b1, 7'd33, 8'b0000_0000);
        check("t4_c1_done", {31'd0, done_o}, 32'd0);
        check("t4_c1_busy", {31'd0, busy}, 32'd1);
        tick();
        check("t4_c2_done", {31'd0, done_o}, 32'd1);
        check("t4_c2_busy", {31'd0, busy}, 32'd0);
        check("t4_c2_ctrl", {31'd0, ctrl_mem}, 32'd0);
        tick();
        check("t4_c3_done", {31'd0, done_o}, 32'd0);
        check("t4_c3_busy", {31'd0, busy}, 32'd0);
        tick();
        check("t4_nwr", wlog.size() - base, 32'd0);
        check("t4_ndone", done_cnt - d0, 32'd1);
        check("t4_cnt", {27'd0, flip_count}, 32'd0);

        // Reset in the cycle after the first flip WR.
        clear_mem();
        poke(6'd21, 2'b01); poke(6'd22, 2'b01); poke(6'd23, 2'b10);
        base = wlog.size();
        run_move(1'b1, 7'd20, 8'b0000_0001);
        for (int i = 0; i < 100; i++) begin
            if (wren_o && (addr_out == 7'd21)) break;
            tick();
        end
        check("t5_flip_seen", {31'd0, wren_o}, 32'd1);
        reset = 1'b0;
        tick();
        check_idle_outputs("t5_rst");
        tick(); tick();
        check("t5_wren_hold", {31'd0, wren_o}, 32'd0);
        reset = 1'b1;
        tick(); tick(); tick();
        check("t5_nwr", wlog.size() - base, 32'd2);
        check("t5_m21", {30'd0, mem[21]}, 32'd2);
        check("t5_m22", {30'd0, mem[22]}, 32'd1);
        // A fresh move runs normally after the abort.
        clear_mem();
        poke(6'd27, 2'b10); poke(6'd35, 2'b01);
        run_move(1'b0, 7'd19, 8'b0000_0100);
        wait_done("t5_rerun_done");
        check("t5_rerun_cnt", {27'd0, flip_count}, 32'd1);
        tick();
        check("t5_rerun_m27", {30'd0, mem[27]}, 32'd1);

        // Start re-pulsed while busy is ignored.
        clear_mem();
        poke(6'd27, 2'b10); poke(6'd35, 2'b01); poke(6'd1, 2'b10); poke(6'd2, 2'b01);
        base = wlog.size(); d0 = done_cnt;
        run_move(1'b0, 7'd19, 8'b0000_0100);
        tick();
        player = 1'b1; s_addr_in = 7'd0; dir_mask = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t6_done");
        check("t6_cnt", {27'd0, flip_count}, 32'd1);
        for (int i = 0; i < 12; i++) tick();
        check("t6_ndone", done_cnt - d0, 32'd1);
        check("t6_nwr", wlog.size() - base, 32'd2);
        check_wr("t6_wr0", base, {7'd19, 2'b01});
        check_wr("t6_wr1", base + 1, {7'd27, 2'b01});
        check("t6_m0", {30'd0, mem[0]}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
